regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). It buffers MDU results in a small FIFO and tracks in-flight MDU destinations in a 32-bit pending scoreboard. It raises a decode-stage hazard stall on RAW/WAW conflicts with pending registers, and forces a one-cycle pipeline writeback hold when MDU results starve. It sits between the WB stage, the MDU and the `registerfile` write inputs (`regwrite`, `rd`, `writedata`).

---
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB stage and
// buffered MDU results, tracking in-flight MDU destinations to flag decode hazards.
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wb_regwrite_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_rd_i,
    input  logic [31:0] mdu_data_i,
    output logic        mdu_ready_o,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic [4:0]  dec_rd_i,
    input  logic        dec_use_rs1_i,
    input  logic        dec_use_rs2_i,
    input  logic        dec_writes_i,
    output logic        hazard_stall_o,
    output logic        wb_hold_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] pending_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  LIMIT_C = 4'(STARVE_LIMIT);

    logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [3:0]    starve_q, starve_d;
    logic          hold_q, hold_d;
    logic [31:0]   pending_q, pending_d;

    logic          fifo_empty, wbreq, grant_fifo, grant_wb, push;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;
    logic [3:0]    starve_inc;
    logic [31:0]   set_mask, clr_mask;

    assign fifo_empty = (count_q == '0);
    assign head_rd    = fifo_rd_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];
    assign wbreq      = wb_regwrite_i & (wb_rd_i != 5'd0) & ~hold_q;
    // The forced-hold cycle always goes to the FIFO head; otherwise the pipeline wins.
    assign grant_fifo = ~reset_i & ~fifo_empty & (hold_q | ~wbreq);
    assign grant_wb   = ~reset_i & wbreq;
    assign mdu_ready_o = ~reset_i & (count_q < DEPTH_C);
    assign push       = mdu_valid_i & mdu_ready_o;

    always_comb begin
        rf_we_o    = 1'b0;
        rf_rd_o    = 5'd0;
        rf_wdata_o = 32'd0;
        if (grant_fifo) begin
            rf_we_o    = (head_rd != 5'd0);
            rf_rd_o    = head_rd;
            rf_wdata_o = head_data;
        end else if (grant_wb) begin
            rf_we_o    = 1'b1;
            rf_rd_o    = wb_rd_i;
            rf_wdata_o = wb_data_i;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = grant_fifo ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(grant_fifo);

        starve_inc = starve_q + 4'd1;
        starve_d   = 4'd0;
        hold_d     = 1'b0;
        if (grant_wb && !fifo_empty) begin
            if (starve_inc == LIMIT_C) begin
                hold_d = 1'b1;
            end else begin
                starve_d = starve_inc;
            end
        end

        set_mask  = (issue_valid_i && issue_rd_i != 5'd0) ? (32'd1 << issue_rd_i) : 32'd0;
        clr_mask  = (grant_fifo && head_rd != 5'd0) ? (32'd1 << head_rd) : 32'd0;
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= 4'd0;
            hold_q    <= 1'b0;
            pending_q <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
        end
    end

    // Entry storage carries no reset; occupancy is governed by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= mdu_rd_i;
            fifo_data_q[wr_ptr_q] <= mdu_data_i;
        end
    end

    assign wb_hold_o = hold_q;
    assign pending_o = pending_q;
    assign hazard_stall_o = (dec_use_rs1_i & (dec_rs1_i != 5'd0) & pending_q[dec_rs1_i])
                          | (dec_use_rs2_i & (dec_rs2_i != 5'd0) & pending_q[dec_rs2_i])
                          | (dec_writes_i  & (dec_rd_i  != 5'd0) & pending_q[dec_rd_i]);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: passthrough, scoreboard/hazard, FIFO full,
// starvation-forced drain and mid-operation reset, with hand-computed expectations.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_use_rs1, dec_use_rs2, dec_writes;
    logic        hazard_stall, wb_hold, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata, pending;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .reset_i(reset),
        .wb_regwrite_i(wb_regwrite), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .mdu_valid_i(mdu_valid), .mdu_rd_i(mdu_rd), .mdu_data_i(mdu_data),
        .mdu_ready_o(mdu_ready),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
        .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2), .dec_rd_i(dec_rd),
        .dec_use_rs1_i(dec_use_rs1), .dec_use_rs2_i(dec_use_rs2), .dec_writes_i(dec_writes),
        .hazard_stall_o(hazard_stall), .wb_hold_o(wb_hold),
        .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_wdata_o(rf_wdata), .pending_o(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle 1 time unit past the edge before driving/checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
        dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_writes = 1'b0;
        tick(); tick();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_wb_hold", wb_hold, 0);
        chk("rst_mdu_ready", mdu_ready, 0);
        chk("rst_hazard", hazard_stall, 0);
        chk("rst_pending", pending, 0);

        reset = 1'b0;
        #1;
        chk("ready_after_reset", mdu_ready, 1);

        // Pipeline passthrough, same cycle
        wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
        chk("pass_we", rf_we, 1);
        chk("pass_rd", rf_rd, 5);
        chk("pass_data", rf_wdata, 32'hDEADBEEF);
        wb_rd = 5'd0;
        #1;
        chk("pass_rd0_we", rf_we, 0);
        wb_regwrite = 1'b0;

        // Scoreboard and RAW hazard on x7
        tick();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("pend_x7", pending, 32'h80);
        dec_use_rs1 = 1'b1; dec_rs1 = 5'd7;
        #1;
        chk("raw_stall", hazard_stall, 1);
        tick();
        chk("raw_stall_hold", hazard_stall, 1);
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h1234;
        tick();
        mdu_valid = 1'b0;
        chk("mdu7_we", rf_we, 1);
        chk("mdu7_rd", rf_rd, 7);
        chk("mdu7_data", rf_wdata, 32'h1234);
        chk("mdu7_stall_same", hazard_stall, 1);
        chk("mdu7_pend_same", pending, 32'h80);
        tick();
        chk("mdu7_pend_clr", pending, 0);
        chk("mdu7_stall_clr", hazard_stall, 0);
        chk("mdu7_idle", rf_we, 0);
        dec_use_rs1 = 1'b0;

        // WAW block on x9, x0 never blocks
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        dec_writes = 1'b1; dec_rd = 5'd9;
        #1;
        chk("waw_stall", hazard_stall, 1);
        dec_rd = 5'd0;
        #1;
        chk("waw_x0", hazard_stall, 0);
        dec_writes = 1'b0;
        dec_use_rs2 = 1'b1; dec_rs2 = 5'd9;
        #1;
        chk("raw_rs2", hazard_stall, 1);
        dec_use_rs2 = 1'b0;
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
        tick();
        mdu_valid = 1'b0;
        chk("mdu9_rd", rf_rd, 9);
        tick();
        chk("mdu9_pend_clr", pending, 0);

        // FIFO full under continuous pipeline writes, then starvation drain
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        tick();
        issue_valid = 1'b0;
        chk("pend_x3x4", pending, 32'h18);
        wb_regwrite = 1'b1; wb_rd = 5'd10; wb_data = 32'hA0;
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h11;
        #1;
        chk("c0_ready", mdu_ready, 1);
        tick();
        mdu_rd = 5'd4; mdu_data = 32'h22;
        chk("c1_ready", mdu_ready, 1);
        chk("c1_pipe_rd", rf_rd, 10);
        tick();
        mdu_rd = 5'd5; mdu_data = 32'h33;
        chk("c2_full", mdu_ready, 0);
        chk("c2_pipe_rd", rf_rd, 10);
        tick();
        mdu_valid = 1'b0;
        chk("c3_hold", wb_hold, 0);
        tick();
        chk("c4_hold", wb_hold, 0);
        chk("c4_pipe_data", rf_wdata, 32'hA0);
        tick();
        chk("c5_hold", wb_hold, 1);
        chk("c5_we", rf_we, 1);
        chk("c5_rd", rf_rd, 3);
        chk("c5_data", rf_wdata, 32'h11);
        tick();
        chk("c6_hold", wb_hold, 0);
        chk("c6_pend", pending, 32'h10);
        chk("c6_pipe_rd", rf_rd, 10);
        chk("c6_ready", mdu_ready, 1);
        for (int i = 7; i <= 9; i++) begin
            tick();
            chk("c7_9_hold", wb_hold, 0);
            chk("c7_9_pipe_rd", rf_rd, 10);
        end
        tick();
        chk("c10_hold", wb_hold, 1);
        chk("c10_rd", rf_rd, 4);
        chk("c10_data", rf_wdata, 32'h22);
        tick();
        chk("c11_hold", wb_hold, 0);
        chk("c11_pend", pending, 0);
        chk("c11_pipe_rd", rf_rd, 10);

        // Reset with one queued entry and x4 pending
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        issue_valid = 1'b0;
        mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h44;
        tick();
        mdu_valid = 1'b0;
        chk("pre_rst_pend", pending, 32'h10);
        chk("pre_rst_rd", rf_rd, 10);
        reset = 1'b1;
        #1;
        chk("in_rst_ready", mdu_ready, 0);
        chk("in_rst_we", rf_we, 0);
        tick();
        chk("post_rst_pend", pending, 0);
        chk("post_rst_we", rf_we, 0);
        chk("post_rst_ready", mdu_ready, 0);
        chk("post_rst_hold", wb_hold, 0);
        wb_regwrite = 1'b0;
        reset = 1'b0;
        #1;
        chk("rel_ready", mdu_ready, 1);
        chk("rel_fifo_empty", rf_we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
